control_cmd_dispatch: RTL and testbench

Byte-stream command dispatcher that sits directly upstream of `control_cmd_readrow` and the fill sub-command. It takes one received byte per `rx_valid` strobe, decodes the first byte of each command as an opcode, and forwards every following payload byte, registered, to the selected sub-command with a one-cycle enable pulse. Routing continues until that sub-command reports `done`. A stalled stream is aborted by an inactivity timeout, and unknown opcodes are flagged and discarded.

---
 rtl/control_cmd_dispatch.sv | 87 ++++++++
 tb/tb_control_cmd_dispatch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_dispatch.sv
// Byte-stream command dispatcher: decodes an opcode byte, then forwards the
// payload bytes to the readrow or fill sub-command until it reports done.
module control_cmd_dispatch #(
    parameter logic [7:0] OPCODE_READROW = 8'h4C,
    parameter logic [7:0] OPCODE_FILL    = 8'h46,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] sub_data,
    output logic       readrow_enable,
    input  logic       readrow_done,
    output logic       fill_enable,
    input  logic       fill_done,
    output logic       sub_abort,
    output logic       busy,
    output logic       err_unknown,
    output logic       err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] ROUTE_READROW = 2'd1;
    localparam logic [1:0] ROUTE_FILL    = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] idle_cnt;
    logic             active_done;
    logic             in_route;

    // Only the done of the sub-command currently being fed ends the command.
    assign active_done = ((state == ROUTE_READROW) && readrow_done) ||
                         ((state == ROUTE_FILL) && fill_done);
    assign in_route    = (state == ROUTE_READROW) || (state == ROUTE_FILL);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idle_cnt       <= '0;
            sub_data       <= 8'h00;
            readrow_enable <= 1'b0;
            fill_enable    <= 1'b0;
            sub_abort      <= 1'b0;
            err_unknown    <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            readrow_enable <= 1'b0;
            fill_enable    <= 1'b0;
            sub_abort      <= 1'b0;
            err_unknown    <= 1'b0;
            err_timeout    <= 1'b0;

            // A byte seen in IDLE, or together with done, is an opcode.
            if (!in_route || active_done) begin
                idle_cnt <= '0;
                state    <= IDLE;
                if (rx_valid) begin
                    if (rx_data == OPCODE_READROW) begin
                        state <= ROUTE_READROW;
                    end else if (rx_data == OPCODE_FILL) begin
                        state <= ROUTE_FILL;
                    end else begin
                        err_unknown <= 1'b1;
                    end
                end
            end else if (rx_valid) begin
                sub_data       <= rx_data;
                readrow_enable <= (state == ROUTE_READROW);
                fill_enable    <= (state == ROUTE_FILL);
                idle_cnt       <= '0;
            end else if (idle_cnt == CNT_LAST) begin
                sub_abort   <= 1'b1;
                err_timeout <= 1'b1;
                state       <= IDLE;
                idle_cnt    <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Self-checking bench for control_cmd_dispatch: directed vector table, hand
// sequences for timeout and reset, and randomized traffic against a model.
module tb_control_cmd_dispatch;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sub_data;
    logic       readrow_enable;
    logic       readrow_done;
    logic       fill_enable;
    logic       fill_done;
    logic       sub_abort;
    logic       busy;
    logic       err_unknown;
    logic       err_timeout;

    int tests_run;
    int tests_failed;

    // Reference model state: which sub-command is selected (0 none, 1 readrow,
    // 2 fill), quiet cycles since the last accepted byte, last forwarded byte.
    int         m_mode;
    int         m_idle;
    logic [7:0] m_data;
    logic [13:0] m_exp;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rd;
        logic        fd;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[24];

    control_cmd_dispatch #(
        .OPCODE_READROW(8'h4C),
        .OPCODE_FILL   (8'h46),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .sub_data      (sub_data),
        .readrow_enable(readrow_enable),
        .readrow_done  (readrow_done),
        .fill_enable   (fill_enable),
        .fill_done     (fill_done),
        .sub_abort     (sub_abort),
        .busy          (busy),
        .err_unknown   (err_unknown),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic [7:0] data, input logic rr,
                                       input logic fl, input logic ab,
                                       input logic bz, input logic eu,
                                       input logic et);
        return {data, rr, fl, ab, bz, eu, et};
    endfunction

    function automatic logic [13:0] actual();
        return {sub_data, readrow_enable, fill_enable, sub_abort, busy,
                err_unknown, err_timeout};
    endfunction

    // Opcode decode shared by IDLE and by the done-with-byte case.
    task automatic model_decode(input logic v, input logic [7:0] d,
                                inout logic [13:0] e);
        m_mode = 0;
        if (v) begin
            if (d == 8'h4C)      m_mode = 1;
            else if (d == 8'h46) m_mode = 2;
            else                 e[1] = 1'b1;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d,
                              input logic rd, input logic fd);
        logic [13:0] e;
        logic        done;
        e = '0;
        done = (m_mode == 1) ? rd : (m_mode == 2) ? fd : 1'b0;
        if (m_mode == 0 || done) begin
            m_idle = 0;
            model_decode(v, d, e);
        end else if (v) begin
            m_data = d;
            m_idle = 0;
            if (m_mode == 1) e[5] = 1'b1;
            else             e[4] = 1'b1;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e[3] = 1'b1;
                e[0] = 1'b1;
                m_mode = 0;
                m_idle = 0;
            end
        end
        e[13:6] = m_data;
        e[2]    = (m_mode != 0);
        m_exp   = e;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic rd, input logic fd);
        rx_valid     = v;
        rx_data      = d;
        readrow_done = rd;
        fill_done    = fd;
        @(posedge clk);
        #1;
        model_step(v, d, rd, fd);
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        readrow_done = 1'b0;
        fill_done    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = actual();
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got data=%h rr=%b fl=%b ab=%b busy=%b eu=%b et=%b, expected data=%h rr=%b fl=%b ab=%b busy=%b eu=%b et=%b",
                     name, act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_mode = 0;
        m_idle = 0;
        m_data = 8'h00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        readrow_done = 1'b0;
        fill_done    = 1'b0;
        reset = 1'b0;

        // Readrow routing, unknown opcode, done+byte, inactive done, back-to-back.
        vecs[0]  = '{1'b1, 8'h4C, 1'b0, 1'b0, mk(8'h00, 0, 0, 0, 1, 0, 0)};
        vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, mk(8'h11, 1, 0, 0, 1, 0, 0)};
        vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, mk(8'h22, 1, 0, 0, 1, 0, 0)};
        vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, mk(8'h33, 1, 0, 0, 1, 0, 0)};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h33, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, mk(8'h33, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{1'b1, 8'h99, 1'b0, 1'b0, mk(8'h33, 0, 0, 0, 0, 1, 0)};
        vecs[7]  = '{1'b1, 8'h46, 1'b0, 1'b0, mk(8'h33, 0, 0, 0, 1, 0, 0)};
        vecs[8]  = '{1'b1, 8'hAA, 1'b0, 1'b0, mk(8'hAA, 0, 1, 0, 1, 0, 0)};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, mk(8'hAA, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1'b1, 8'h4C, 1'b0, 1'b0, mk(8'hAA, 0, 0, 0, 1, 0, 0)};
        vecs[11] = '{1'b1, 8'h77, 1'b0, 1'b0, mk(8'h77, 1, 0, 0, 1, 0, 0)};
        vecs[12] = '{1'b1, 8'h46, 1'b1, 1'b0, mk(8'h77, 0, 0, 0, 1, 0, 0)};
        vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b0, mk(8'h55, 0, 1, 0, 1, 0, 0)};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h55, 0, 0, 0, 1, 0, 0)};
        vecs[15] = '{1'b1, 8'h01, 1'b0, 1'b0, mk(8'h01, 0, 1, 0, 1, 0, 0)};
        vecs[16] = '{1'b1, 8'h02, 1'b0, 1'b0, mk(8'h02, 0, 1, 0, 1, 0, 0)};
        vecs[17] = '{1'b1, 8'h03, 1'b0, 1'b0, mk(8'h03, 0, 1, 0, 1, 0, 0)};
        vecs[18] = '{1'b1, 8'h04, 1'b0, 1'b0, mk(8'h04, 0, 1, 0, 1, 0, 0)};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, mk(8'h04, 0, 0, 0, 0, 0, 0)};
        vecs[20] = '{1'b1, 8'h4C, 1'b0, 1'b0, mk(8'h04, 0, 0, 0, 1, 0, 0)};
        vecs[21] = '{1'b1, 8'h12, 1'b0, 1'b0, mk(8'h12, 1, 0, 0, 1, 0, 0)};
        vecs[22] = '{1'b1, 8'h99, 1'b1, 1'b0, mk(8'h12, 0, 0, 0, 0, 1, 0)};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b1, mk(8'h12, 0, 0, 0, 0, 0, 0)};

        #12;
        checkOutput("reset_state", mk(8'h00, 0, 0, 0, 0, 0, 0));
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].fd);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Timeout fires on the TO-th quiet cycle after the last payload byte.
        applyStimulus(1'b1, 8'h4C, 1'b0, 1'b0);
        checkOutput("to_opcode", mk(8'h12, 0, 0, 0, 1, 0, 0));
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        checkOutput("to_payload", mk(8'h01, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i < TO; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput($sformatf("to_wait%0d", i), mk(8'h01, 0, 0, 0, 1, 0, 0));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_fire", mk(8'h01, 0, 0, 1, 0, 0, 1));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_after", mk(8'h01, 0, 0, 0, 0, 0, 0));

        // Done coinciding with the timeout cycle returns cleanly.
        applyStimulus(1'b1, 8'h4C, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        checkOutput("tod_payload", mk(8'h02, 1, 0, 0, 1, 0, 0));
        for (int i = 1; i < TO; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("tod_wait", mk(8'h02, 0, 0, 0, 1, 0, 0));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("tod_done", mk(8'h02, 0, 0, 0, 0, 0, 0));

        // A byte on the last allowed cycle keeps the command alive.
        applyStimulus(1'b1, 8'h46, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        for (int i = 1; i < TO; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("tor_byte", mk(8'h05, 0, 1, 0, 1, 0, 0));
        for (int i = 1; i < TO; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("tor_wait", mk(8'h05, 0, 0, 0, 1, 0, 0));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("tor_done", mk(8'h05, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a readrow command.
        applyStimulus(1'b1, 8'h4C, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("rst_before", mk(8'h10, 1, 0, 0, 1, 0, 0));
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async", mk(8'h00, 0, 0, 0, 0, 0, 0));
        m_mode = 0;
        m_idle = 0;
        m_data = 8'h00;
        #3 reset = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("rst_payload", mk(8'h00, 0, 0, 0, 0, 1, 0));

        // Randomized traffic: dense bytes first, then sparse to reach timeouts.
        for (int i = 0; i < 800; i++) begin
            logic       v;
            logic [7:0] d;
            int         sel;
            v = (i < 400) ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
            sel = $urandom_range(3);
            d = (sel == 0) ? 8'h4C : (sel == 1) ? 8'h46 : 8'($urandom);
            applyStimulus(v, d, $urandom_range(7) == 0, $urandom_range(7) == 0);
            checkOutput($sformatf("rand%0d", i), m_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
